// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding,
// parameter defaults and the prefetch queue entry layout.
package ifetch_pkg;

  // Fetch-stage operating mode.
  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } ifetch_state_e;

  localparam int unsigned IFETCH_IW       = 16;
  localparam int unsigned IFETCH_AW       = 32;
  localparam int unsigned IFETCH_DEPTH    = 4;
  localparam int unsigned IFETCH_PC_STEP  = 1;
  localparam int unsigned IFETCH_RESET_PC = 0;

  // A queue entry is {pc[AW-1:0], inst[IW-1:0]}; the PC sits in the upper bits.
  function automatic int unsigned entry_width(input int unsigned aw, input int unsigned iw);
    return aw + iw;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH-entry circular buffer with synchronous push, pop and
// flush. Head entry is presented combinationally on rdata.
module fetch_fifo #(
  parameter int unsigned W     = 48,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  logic [W-1:0]              wdata,
  output logic [W-1:0]              rdata,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW:0]   count_q;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_COUNT);
  assign do_push = push & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = mem[rd_ptr_q];
  assign count   = count_q;

  // Pointer and occupancy bookkeeping; flush empties the queue in one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + (PW + 1)'(do_push) - (PW + 1)'(do_pop);
    end
  end

  // Entry storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; an entry is only read while
    // count says it holds a pushed value, so its power-up contents never leak.
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  // The fetch credit rule must never let a return land on a full queue.
  a_no_push_when_full : assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/inst_prefetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues reads to a synchronous
// instruction memory, buffers returned words with their PC and hands them to
// decode over valid/ready. Redirect flushes; LOAD mode hands memory to a loader.
module inst_prefetch_unit
  import ifetch_pkg::*;
#(
  parameter int unsigned IW       = IFETCH_IW,
  parameter int unsigned AW       = IFETCH_AW,
  parameter int unsigned DEPTH    = IFETCH_DEPTH,
  parameter int unsigned PC_STEP  = IFETCH_PC_STEP,
  parameter int unsigned RESET_PC = IFETCH_RESET_PC
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_en,
  input  logic          redirect_en,
  input  logic [AW-1:0] redirect_pc,
  input  logic          mem_load,
  input  logic [AW-1:0] load_addr,
  input  logic          load_we,
  input  logic [IW-1:0] load_wdata,
  output logic [AW-1:0] imem_addr,
  output logic          imem_we,
  output logic [IW-1:0] imem_wdata,
  input  logic [IW-1:0] imem_rdata,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [IW-1:0] inst_data,
  output logic [AW-1:0] inst_pc,
  output logic [AW-1:0] curr_pc
);

  localparam int unsigned   EW     = entry_width(AW, IW);
  localparam int unsigned   CW     = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] PC_INC = AW'(PC_STEP);
  localparam logic [AW-1:0] PC_RST = AW'(RESET_PC);

  ifetch_state_e state_q, state_d;
  logic [AW-1:0] curr_pc_q, pc_d;
  logic [AW-1:0] issue_pc_q;
  logic          inflight_q;
  logic          kill_q;
  logic          issue;
  logic          flush;
  logic          kill_now;
  logic          push;
  logic          pop;
  logic          credit_ok;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic [EW-1:0] fifo_head;
  logic [EW-1:0] head_shown;
  logic [EW-1:0] hold_q;

  // Memory port: the loader owns the address while mem_load is high.
  assign imem_addr  = mem_load ? load_addr : curr_pc_q;
  assign imem_we    = mem_load & load_we;
  assign imem_wdata = load_wdata;

  // A new read may issue only if the queue has room for everything in flight.
  assign credit_ok = (fifo_count + CW'(inflight_q)) < CW'(DEPTH);

  // A return is dropped if its read was issued under a kill or one arrives now.
  assign push = inflight_q & ~kill_q & ~kill_now;
  assign pop  = inst_valid & inst_ready & ~flush;

  // Mode transitions, PC update, issue and flush decisions.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d  = state_q;
    pc_d     = curr_pc_q;
    issue    = 1'b0;
    flush    = 1'b0;
    kill_now = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_load) begin
          state_d  = LOAD;
          flush    = 1'b1;
          kill_now = 1'b1;
        end else if (redirect_en) begin
          pc_d     = redirect_pc;
          flush    = 1'b1;
          kill_now = 1'b1;
        end else if (fetch_en && credit_ok) begin
          issue = 1'b1;
          pc_d  = curr_pc_q + PC_INC;
        end
      end
      LOAD: begin
        // Queue stays empty and redirects are ignored until the loader leaves.
        flush    = 1'b1;
        kill_now = 1'b1;
        if (!mem_load) begin
          state_d = RUN;
          pc_d    = PC_RST;
        end
      end
    endcase
  end

  // State, fetch PC and in-flight read tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      curr_pc_q  <= PC_RST;
      issue_pc_q <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      curr_pc_q  <= pc_d;
      inflight_q <= issue;
      kill_q     <= kill_now;
      if (issue) issue_pc_q <= curr_pc_q;
    end
  end

  fetch_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata ({issue_pc_q, imem_rdata}),
    .rdata (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  // Decode sees the queue head; with an empty queue the last shown entry is held.
  assign head_shown = fifo_empty ? hold_q : fifo_head;

  // Remember whatever was last shown so outputs stay put while the queue is empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hold_q <= '0;
    else      hold_q <= head_shown;
  end

  assign inst_valid = ~fifo_empty;
  assign inst_pc    = head_shown[EW-1 -: AW];
  assign inst_data  = head_shown[IW-1:0];
  assign curr_pc    = curr_pc_q;

endmodule
